// File: rtl/cv32e40p_core_v_xif_pkg.sv
// rtl/cv32e40p_core_v_xif_pkg.sv - CORE-V-X-IF shared types for the result buffer
package cv32e40p_core_v_xif_pkg;

    localparam int X_RESULT_BUF_DEPTH = 2;

    typedef struct packed {
        logic [3:0]  id;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we;
    } x_result_entry_t;

endpackage

// File: rtl/cv32e40p_x_result_fifo.sv
// rtl/cv32e40p_x_result_fifo.sv - circular FIFO of x_result_entry_t with head read
module cv32e40p_x_result_fifo
    import cv32e40p_core_v_xif_pkg::*;
#(
    parameter int DEPTH = X_RESULT_BUF_DEPTH
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  x_result_entry_t data_i,
    input  logic            pop_i,
    output x_result_entry_t head_o,
    output logic            empty_o,
    output logic            full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    x_result_entry_t mem_q [DEPTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so plain increment wraps the pointers
    always_comb begin
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end
    end

endmodule

// File: rtl/cv32e40p_x_result_buf.sv
// rtl/cv32e40p_x_result_buf.sv - X-IF result buffer feeding idle RF write slots; CV32E40P_X_RESULT_BYPASS_EN enables same-cycle bypass
module cv32e40p_x_result_buf
    import cv32e40p_core_v_xif_pkg::*;
#(
    parameter int DEPTH = X_RESULT_BUF_DEPTH
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        x_result_valid_i,
    output logic        x_result_ready_o,
    input  logic [3:0]  x_result_id_i,
    input  logic [31:0] x_result_data_i,
    input  logic [4:0]  x_result_rd_i,
    input  logic        x_result_we_i,
    input  logic        core_wb_we_i,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        sb_clr_valid_o,
    output logic [4:0]  sb_clr_rd_o,
    output logic [3:0]  retire_id_o,
    output logic        buf_empty_o,
    output logic        buf_full_o
);

    x_result_entry_t in_entry;
    x_result_entry_t head;
    x_result_entry_t ret;
    logic            empty, full, push, pop, retire;

    assign in_entry = '{id: x_result_id_i, rd: x_result_rd_i,
                        data: x_result_data_i, we: x_result_we_i};

    cv32e40p_x_result_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (push),
        .data_i (in_entry),
        .pop_i  (pop),
        .head_o (head),
        .empty_o(empty),
        .full_o (full)
    );

    assign x_result_ready_o = ~full;
    assign buf_empty_o      = empty;
    assign buf_full_o       = full;

    // Writing heads wait for an idle RF port; non-writing heads leave at once
    always_comb begin
        retire = 1'b0;
        pop    = 1'b0;
        ret    = head;
        if (!empty) begin
            retire = ~head.we | ~core_wb_we_i;
            pop    = retire;
        end
`ifdef CV32E40P_X_RESULT_BYPASS_EN
        else if (x_result_valid_i && (!core_wb_we_i || !x_result_we_i)) begin
            retire = 1'b1;
            ret    = in_entry;
        end
`endif
    end

`ifdef CV32E40P_X_RESULT_BYPASS_EN
    assign push = x_result_valid_i & ~full & ~(empty & retire);
`else
    assign push = x_result_valid_i & ~full;
`endif

    // x0 writes still retire and clear the scoreboard, but never hit the RF
    assign rf_we_o        = retire & ret.we & (ret.rd != 5'd0);
    assign rf_waddr_o     = (retire & ret.we) ? ret.rd : 5'd0;
    assign rf_wdata_o     = (retire & ret.we) ? ret.data : 32'd0;
    assign sb_clr_valid_o = retire & ret.we;
    assign sb_clr_rd_o    = (retire & ret.we) ? ret.rd : 5'd0;
    assign retire_id_o    = retire ? ret.id : 4'd0;

endmodule

// File: tb/tb_cv32e40p_x_result_buf.sv
// tb/tb_cv32e40p_x_result_buf.sv - scoreboard bench for cv32e40p_x_result_buf
module tb_cv32e40p_x_result_buf;
    import cv32e40p_core_v_xif_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        x_result_valid_i;
    logic        x_result_ready_o;
    logic [3:0]  x_result_id_i;
    logic [31:0] x_result_data_i;
    logic [4:0]  x_result_rd_i;
    logic        x_result_we_i;
    logic        core_wb_we_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        sb_clr_valid_o;
    logic [4:0]  sb_clr_rd_o;
    logic [3:0]  retire_id_o;
    logic        buf_empty_o;
    logic        buf_full_o;

`ifdef CV32E40P_X_RESULT_BYPASS_EN
    localparam logic SAME_CYCLE = 1'b1;
`else
    localparam logic SAME_CYCLE = 1'b0;
`endif

    x_result_entry_t sbq[$];
    int              ret_cyc[$];
    int              cyc = 0;
    int              checks = 0;
    int              passes = 0;

    always #5 clk_i = ~clk_i;

    cv32e40p_x_result_buf dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .x_result_valid_i(x_result_valid_i),
        .x_result_ready_o(x_result_ready_o),
        .x_result_id_i   (x_result_id_i),
        .x_result_data_i (x_result_data_i),
        .x_result_rd_i   (x_result_rd_i),
        .x_result_we_i   (x_result_we_i),
        .core_wb_we_i    (core_wb_we_i),
        .rf_we_o         (rf_we_o),
        .rf_waddr_o      (rf_waddr_o),
        .rf_wdata_o      (rf_wdata_o),
        .sb_clr_valid_o  (sb_clr_valid_o),
        .sb_clr_rd_o     (sb_clr_rd_o),
        .retire_id_o     (retire_id_o),
        .buf_empty_o     (buf_empty_o),
        .buf_full_o      (buf_full_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ready"},  32'(x_result_ready_o), 32'd1);
        chk({tag, "_empty"},  32'(buf_empty_o),      32'd1);
        chk({tag, "_full"},   32'(buf_full_o),       32'd0);
        chk({tag, "_rf_we"},  32'(rf_we_o),          32'd0);
        chk({tag, "_clr_v"},  32'(sb_clr_valid_o),   32'd0);
        chk({tag, "_waddr"},  32'(rf_waddr_o),       32'd0);
        chk({tag, "_wdata"},  rf_wdata_o,            32'd0);
        chk({tag, "_clr_rd"}, 32'(sb_clr_rd_o),      32'd0);
        chk({tag, "_rid"},    32'(retire_id_o),      32'd0);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [3:0] id, input logic [4:0] rd,
                        input logic [31:0] data, input logic we);
        int n;
        n = 0;
        x_result_valid_i = 1'b1;
        x_result_id_i    = id;
        x_result_rd_i    = rd;
        x_result_data_i  = data;
        x_result_we_i    = we;
        while (!x_result_ready_o && n < 50) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            $display("FAIL send_timeout: id %0d never accepted", id);
        end else begin
            sbq.push_back('{id: id, rd: rd, data: data, we: we});
            @(posedge clk_i); #1;
        end
    endtask

    always @(negedge clk_i) begin
        x_result_entry_t e;
        logic            ok;
        logic            exp_we;
        cyc++;
        if (rst_ni === 1'b1 && (rf_we_o || sb_clr_valid_o || retire_id_o != 4'd0)) begin
            checks++;
            if (sbq.size() == 0) begin
                $display("FAIL unexpected_retire: got id=%0d rf_we=%b clr=%b required no retire",
                         retire_id_o, rf_we_o, sb_clr_valid_o);
            end else begin
                e = sbq.pop_front();
                ret_cyc.push_back(cyc);
                exp_we = e.we && (e.rd != 5'd0);
                ok = (retire_id_o == e.id) && (rf_we_o == exp_we) && (sb_clr_valid_o == e.we)
                     && (!e.we || sb_clr_rd_o == e.rd)
                     && (!exp_we || (rf_waddr_o == e.rd && rf_wdata_o == e.data));
                if (ok) passes++;
                else $display("FAIL retire: got id=%0d rf_we=%b waddr=%0d wdata=%h clr=%b clr_rd=%0d required id=%0d rd=%0d data=%h we=%b",
                              retire_id_o, rf_we_o, rf_waddr_o, rf_wdata_o, sb_clr_valid_o,
                              sb_clr_rd_o, e.id, e.rd, e.data, e.we);
            end
        end
    end

    initial begin
        rst_ni           = 1'b1;
        x_result_valid_i = 1'b0;
        x_result_id_i    = '0;
        x_result_rd_i    = '0;
        x_result_data_i  = '0;
        x_result_we_i    = 1'b0;
        core_wb_we_i     = 1'b0;
        #1 rst_ni = 1'b0;
        #2 check_reset("rst");
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("idle_ready", 32'(x_result_ready_o), 32'd1);
        chk("idle_empty", 32'(buf_empty_o), 32'd1);
        chk("idle_rf_we", 32'(rf_we_o), 32'd0);
        chk("idle_clr",   32'(sb_clr_valid_o), 32'd0);
        @(posedge clk_i); #1;

        // single result: latency 1 without bypass, 0 with bypass
        x_result_valid_i = 1'b1;
        x_result_id_i    = 4'd3;
        x_result_rd_i    = 5'd5;
        x_result_data_i  = 32'hDEADBEEF;
        x_result_we_i    = 1'b1;
        chk("single_ready", 32'(x_result_ready_o), 32'd1);
        sbq.push_back('{id: 4'd3, rd: 5'd5, data: 32'hDEADBEEF, we: 1'b1});
        @(negedge clk_i);
        chk("lat_same", 32'(rf_we_o), 32'(SAME_CYCLE));
        @(posedge clk_i); #1;
        x_result_valid_i = 1'b0;
        @(negedge clk_i);
        chk("lat_next", 32'(rf_we_o), 32'(!SAME_CYCLE));
        @(posedge clk_i); #1;

        // stalled writes fill the buffer, then drain on consecutive cycles
        core_wb_we_i = 1'b1;
        send(4'd1, 5'd1, 32'h1111_0001, 1'b1);
        send(4'd2, 5'd2, 32'h2222_0002, 1'b1);
        x_result_valid_i = 1'b0;
        chk("stall_full",  32'(buf_full_o), 32'd1);
        chk("stall_ready", 32'(x_result_ready_o), 32'd0);
        chk("stall_hold",  32'(sbq.size()), 32'd2);
        ret_cyc.delete();
        core_wb_we_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1;
        chk("stall_n", 32'(ret_cyc.size()), 32'd2);
        if (ret_cyc.size() == 2) chk("stall_consec", 32'(ret_cyc[1] - ret_cyc[0]), 32'd1);

        // non-writing result retires despite a busy RF port
        core_wb_we_i = 1'b1;
        send(4'd9, 5'd7, 32'h0BAD_F00D, 1'b0);
        x_result_valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("we0_done", 32'(sbq.size()), 32'd0);

        // full buffer, continuous valid, one retire per cycle, ids 0..7
        ret_cyc.delete();
        send(4'd0, 5'd8, 32'hA5A5_0000, 1'b1);
        send(4'd1, 5'd9, 32'hA5A5_0001, 1'b1);
        core_wb_we_i = 1'b0;
        for (int i = 2; i < 8; i++) begin
            send(4'(i), 5'(8 + i), 32'hA5A5_0000 | 32'(i), 1'b1);
        end
        x_result_valid_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1;
        chk("stream_n", 32'(ret_cyc.size()), 32'd8);
        if (ret_cyc.size() == 8) chk("stream_rate", 32'(ret_cyc[7] - ret_cyc[0]), 32'd7);

        // x0 destination: no RF write, scoreboard still cleared
        send(4'd12, 5'd0, 32'hFFFF_FFFF, 1'b1);
        x_result_valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("x0_done", 32'(sbq.size()), 32'd0);

        // reset with two entries held discards them
        core_wb_we_i = 1'b1;
        send(4'd10, 5'd3, 32'h3333_3333, 1'b1);
        send(4'd11, 5'd4, 32'h4444_4444, 1'b1);
        x_result_valid_i = 1'b0;
        chk("pre_rst_full", 32'(buf_full_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        check_reset("midrst");
        sbq.delete();
        core_wb_we_i = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        repeat (5) @(posedge clk_i);
        #1;
        chk("post_rst_empty", 32'(buf_empty_o), 32'd1);
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
